// File: rtl/top_r2_pkg.sv
// Shared types and constants for the radix-2 divider slice.
package top_r2_pkg;

  localparam int unsigned DEF_WIDTH    = 32;
  localparam int unsigned DEF_EXPWIDTH = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    CALC = 2'd2,
    FIX  = 2'd3
  } state_t;

  // Most-negative value of a w-bit two's complement word (w <= 64).
  function automatic logic [63:0] ovf_quot(input int unsigned w);
    return 64'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/top_r2_lzc.sv
// Combinational leading-zero counter; returns WIDTH for an all-zero input.
module top_r2_lzc #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned EXPWIDTH = 6
) (
  input  logic [WIDTH-1:0]    a,
  output logic [EXPWIDTH-1:0] cnt
);

  always_comb begin
    cnt = EXPWIDTH'(WIDTH);
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (a[i]) cnt = EXPWIDTH'(WIDTH - 1 - i);
    end
  end

endmodule

// File: rtl/top_r2_div.sv
// Iterative radix-2 restoring divider, signed/unsigned, free/valid_in start and done pulse.
// Build option: TOP_R2_LZC_SKIP_EN enables the leading-zero iteration skip and early out.
module top_r2_div
  import top_r2_pkg::*;
#(
  parameter int unsigned WIDTH    = DEF_WIDTH,
  parameter int unsigned EXPWIDTH = DEF_EXPWIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] zdividend,
  input  logic [WIDTH-1:0] zdivisor,
  input  logic             valid_in,
  input  logic             sign,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             done,
  output logic             free,
  output logic             sign_o
);

  localparam logic [WIDTH-1:0] OVF = WIDTH'(ovf_quot(WIDTH));

  state_t                state;
  logic [WIDTH-1:0]      n_reg, d_reg;
  logic                  sgn_reg;
  logic [WIDTH:0]        rem;
  logic [2*WIDTH-1:0]    dsh;
  logic [WIDTH-1:0]      q_acc;
  logic [EXPWIDTH-1:0]   cnt;

  logic                  n_neg, d_neg, d_zero, n_zero;
  logic [WIDTH-1:0]      n_abs, d_abs;
  logic [EXPWIDTH-1:0]   lzc_n, lzc_d;
  logic [EXPWIDTH-1:0]   shamt, iters;
  logic                  ge;
  logic [WIDTH:0]        diff;
  logic                  q_neg, r_neg;

  assign n_neg = sgn_reg & n_reg[WIDTH-1];
  assign d_neg = sgn_reg & d_reg[WIDTH-1];
  assign n_abs = n_neg ? -n_reg : n_reg;
  assign d_abs = d_neg ? -d_reg : d_reg;

  top_r2_lzc #(.WIDTH(WIDTH), .EXPWIDTH(EXPWIDTH)) u_lzc_n (.a(n_abs), .cnt(lzc_n));
  top_r2_lzc #(.WIDTH(WIDTH), .EXPWIDTH(EXPWIDTH)) u_lzc_d (.a(d_abs), .cnt(lzc_d));

  assign d_zero = (lzc_d == EXPWIDTH'(WIDTH));
  assign n_zero = (lzc_n == EXPWIDTH'(WIDTH));

  always_comb begin
`ifdef TOP_R2_LZC_SKIP_EN
    shamt = lzc_d - lzc_n;
    iters = (d_zero || (n_abs < d_abs)) ? '0 : shamt + EXPWIDTH'(1);
`else
    shamt = EXPWIDTH'(WIDTH - 1);
    iters = d_zero ? '0 : EXPWIDTH'(WIDTH);
`endif
  end

  // The divisor register is 2*WIDTH wide so the fixed-iteration build can
  // align it at WIDTH-1 without a separate shift-left remainder datapath.
  assign ge   = (dsh <= {{(WIDTH-1){1'b0}}, rem});
  assign diff = rem - dsh[WIDTH:0];

  assign q_neg = (n_neg ^ d_neg) & (q_acc != '0);
  assign r_neg = n_neg & ~n_zero;

  assign free = (state == IDLE);

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state   <= IDLE;
      n_reg   <= '0;
      d_reg   <= '0;
      sgn_reg <= 1'b0;
      rem     <= '0;
      dsh     <= '0;
      q_acc   <= '0;
      cnt     <= '0;
      q       <= '0;
      r       <= '0;
      sign_o  <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (valid_in) begin
            n_reg   <= zdividend;
            d_reg   <= zdivisor;
            sgn_reg <= sign;
            state   <= NORM;
          end
        end
        NORM: begin
          rem   <= {1'b0, n_abs};
          dsh   <= {{WIDTH{1'b0}}, d_abs} << shamt;
          q_acc <= '0;
          cnt   <= iters;
          state <= (iters == '0) ? FIX : CALC;
        end
        CALC: begin
          if (ge) rem <= diff;
          q_acc <= {q_acc[WIDTH-2:0], ge};
          dsh   <= dsh >> 1;
          cnt   <= cnt - EXPWIDTH'(1);
          if (cnt == EXPWIDTH'(1)) state <= FIX;
        end
        FIX: begin
          if (d_zero) begin
            q <= '1;
            r <= n_reg;
          end else if (sgn_reg && (n_reg == OVF) && (d_reg == '1)) begin
            q <= OVF;
            r <= '0;
          end else begin
            q <= q_neg ? -q_acc : q_acc;
            r <= r_neg ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
          end
          sign_o <= sgn_reg;
          done   <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_top_r2_div.sv
// Self-checking bench for top_r2_div: directed vector table plus handshake/reset sequences.
module tb_top_r2_div;

  localparam int unsigned W = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [W-1:0]  zdividend, zdivisor;
  logic          valid_in, sign;
  logic [W-1:0]  q, r;
  logic          done, free, sign_o;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  top_r2_div #(.WIDTH(W), .EXPWIDTH(6)) dut (
    .clk(clk), .rst_n(rst_n), .zdividend(zdividend), .zdivisor(zdivisor),
    .valid_in(valid_in), .sign(sign), .q(q), .r(r), .done(done),
    .free(free), .sign_o(sign_o)
  );

  typedef struct {
    logic [W-1:0] n;
    logic [W-1:0] d;
    logic         s;
    logic [W-1:0] eq;
    logic [W-1:0] er;
    int           lat;   // latency with the lzc skip enabled
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic int exp_lat(input int skip_lat, input logic [W-1:0] d);
`ifdef TOP_R2_LZC_SKIP_EN
    return skip_lat;
`else
    return (d == '0) ? 2 : W + 2;
`endif
  endfunction

  task automatic start_op(input logic [W-1:0] n, input logic [W-1:0] d, input logic s);
    @(negedge clk);
    zdividend = n;
    zdivisor  = d;
    sign      = s;
    valid_in  = 1'b1;
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    chk("free_after_accept", {31'd0, free}, 32'd0);
  endtask

  task automatic wait_done(output int lat);
    lat = -1;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  initial begin
    int lat;
    int spurious;
    logic [W-1:0] prev_q;
    logic held;

    vecs[0]  = '{32'd100,       32'd7,         1'b0, 32'd14,        32'd2,         7};
    vecs[1]  = '{32'hFFFFFF9C,  32'd7,         1'b1, 32'hFFFFFFF2,  32'hFFFFFFFE,  7};
    vecs[2]  = '{32'd100,       32'hFFFFFFF9,  1'b1, 32'hFFFFFFF2,  32'd2,         7};
    vecs[3]  = '{32'hFFFFFF9C,  32'hFFFFFFF9,  1'b1, 32'd14,        32'hFFFFFFFE,  7};
    vecs[4]  = '{32'h12345678,  32'd0,         1'b0, 32'hFFFFFFFF,  32'h12345678,  2};
    vecs[5]  = '{32'h12345678,  32'd0,         1'b1, 32'hFFFFFFFF,  32'h12345678,  2};
    vecs[6]  = '{32'h80000000,  32'hFFFFFFFF,  1'b1, 32'h80000000,  32'd0,         34};
    vecs[7]  = '{32'hFFFFFFFF,  32'd1,         1'b0, 32'hFFFFFFFF,  32'd0,         34};
    vecs[8]  = '{32'd5,         32'd9,         1'b0, 32'd0,         32'd5,         2};
    vecs[9]  = '{32'hFFFFFFFB,  32'd9,         1'b1, 32'd0,         32'hFFFFFFFB,  2};
    vecs[10] = '{32'd0,         32'd3,         1'b0, 32'd0,         32'd0,         2};
    vecs[11] = '{32'hFFFFFFFF,  32'hFFFFFFFF,  1'b0, 32'd1,         32'd0,         3};
    vecs[12] = '{32'hFFFFFF9C,  32'd7,         1'b0, 32'h24924916,  32'd2,         32};
    vecs[13] = '{32'd7,         32'hFFFFFFFE,  1'b1, 32'hFFFFFFFD,  32'd1,         4};
    vecs[14] = '{32'hFFFFFFF9,  32'd2,         1'b1, 32'hFFFFFFFD,  32'hFFFFFFFF,  4};
    vecs[15] = '{32'd6,         32'hFFFFFFFD,  1'b1, 32'hFFFFFFFE,  32'd0,         4};

    rst_n = 1'b1;
    valid_in = 1'b0;
    zdividend = '0;
    zdivisor = '0;
    sign = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_q", q, 32'd0);
    chk("rst_r", r, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_free", {31'd0, free}, 32'd1);
    chk("rst_sign_o", {31'd0, sign_o}, 32'd0);
    @(negedge clk);
    rst_n = 1'b0;

    for (int i = 0; i < 16; i++) begin
      start_op(vecs[i].n, vecs[i].d, vecs[i].s);
      wait_done(lat);
      chk($sformatf("v%0d_lat", i), 32'(lat), 32'(exp_lat(vecs[i].lat, vecs[i].d)));
      chk($sformatf("v%0d_q", i), q, vecs[i].eq);
      chk($sformatf("v%0d_r", i), r, vecs[i].er);
      chk($sformatf("v%0d_sign_o", i), {31'd0, sign_o}, {31'd0, vecs[i].s});
      chk($sformatf("v%0d_free_with_done", i), {31'd0, free}, 32'd1);
    end

    // Back-to-back: valid_in stays high throughout; busy-time operands must be ignored.
    @(negedge clk);
    zdividend = 32'hFFFFFFFF;
    zdivisor  = 32'd1;
    sign      = 1'b0;
    valid_in  = 1'b1;
    @(posedge clk);
    #1;
    zdividend = 32'h00000055;
    zdivisor  = 32'd0;
    sign      = 1'b1;
    chk("b2b_free_busy", {31'd0, free}, 32'd0);
    prev_q = q;
    held = 1'b1;
    lat = -1;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = k;
        break;
      end
      if (q !== prev_q || free) held = 1'b0;
    end
    chk("b2b1_lat", 32'(lat), 32'd34);
    chk("b2b1_q", q, 32'hFFFFFFFF);
    chk("b2b1_r", r, 32'd0);
    chk("b2b1_sign_o", {31'd0, sign_o}, 32'd0);
    chk("b2b1_hold_busy", {31'd0, held}, 32'd1);
    zdividend = 32'd100;
    zdivisor  = 32'd7;
    sign      = 1'b0;
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    chk("b2b2_done_pulse", {31'd0, done}, 32'd0);
    chk("b2b2_free", {31'd0, free}, 32'd0);
    wait_done(lat);
    chk("b2b2_lat", 32'(lat), 32'(exp_lat(7, 32'd7)));
    chk("b2b2_q", q, 32'd14);
    chk("b2b2_r", r, 32'd2);

    // Reset in the middle of CALC aborts without a done.
    start_op(32'hFFFFFFFF, 32'd1, 1'b0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_free", {31'd0, free}, 32'd1);
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk("midrst_q", q, 32'd0);
    chk("midrst_r", r, 32'd0);
    @(negedge clk);
    rst_n = 1'b0;
    spurious = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (done) spurious++;
    end
    chk("midrst_no_done", 32'(spurious), 32'd0);
    chk("midrst_still_free", {31'd0, free}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/top_r2_div.md
# top_r2_div

Iterative radix-2 integer divider producing a WIDTH-bit quotient and remainder for signed or unsigned operands. A leading-zero count skips the quotient bits that must be zero. It is a stand-alone arithmetic engine with a free/valid_in start handshake and a one-cycle done pulse, intended to sit behind an execute-stage issue port.

## Interface
- WIDTH, 32: operand and result width.
- EXPWIDTH, 6: width of leading-zero counts and the iteration counter; at least clog2(WIDTH)+1.

- clk  in  1  sole clock; everything is updated on the rising edge.
- rst_n  in  1  synchronous, active-high reset, despite the _n suffix.
- zdividend  in  WIDTH  dividend; sampled on acceptance.
- zdivisor  in  WIDTH  divisor; sampled on acceptance.
- valid_in  in  1  start request.
- sign  in  1  1 = operands are two's complement, 0 = unsigned; sampled on acceptance.
- q  out  WIDTH  quotient, registered.
- r  out  WIDTH  remainder, registered.
- done  out  1  one-cycle pulse marking q/r/sign_o valid.
- free  out  1  high when a new operation can be accepted.
- sign_o  out  1  sign mode of the completed operation, registered.

## Operation
- States: IDLE, NORM, CALC, FIX.
- IDLE: free=1. valid_in=1 accepts the operands and sign, then moves to NORM. valid_in is ignored in every other state.
- NORM:
  - In signed mode, take the absolute values |n| and |d|.
  - Compute lzc(|n|) and lzc(|d|).
  - Set iters = lzc(|d|) − lzc(|n|) + 1.
  - iters = 0 when |d| = 0 or |n| < |d| (early out).
  - Left-align the divisor by the lzc difference.
  - Next state is CALC, or FIX when iters = 0.
- CALC: one restoring step per cycle.
  - Form a trial subtract of the shifted divisor from the partial remainder.
  - If the result is non-negative, shift in quotient bit 1 and keep the difference; otherwise shift in 0.
  - Shift the divisor right by 1.
  - Leave for FIX after iters cycles.
- FIX: apply signs and special cases, register q, r, sign_o, and go to IDLE with done=1.
- Sign rules (signed mode):
  - Quotient is negative iff the operand signs differ and the quotient is nonzero.
  - Remainder takes the sign of the dividend.
  - Results truncate toward zero.
- Divide by zero: q = all ones, r = zdividend, in both modes.
- Signed overflow (−2^(WIDTH−1) / −1): q = −2^(WIDTH−1), r = 0.
- Early out with a nonzero divisor: q = 0, r = zdividend.
- Internal arithmetic uses a WIDTH+1-bit partial remainder; the unsigned magnitude of −2^(WIDTH−1) must be representable.

## Timing
- Reset values: q=0, r=0, sign_o=0, done=0, free=1, state IDLE.
- Reset mid-operation aborts the operation; no done is issued.
- The acceptance edge is edge 0. done is high in the cycle after edge 2+iters.
  - Minimum is 2 cycles (zero divisor or |n|<|d|).
  - Maximum is WIDTH+2 = 34.
- free drops in the cycle after acceptance and rises together with done.
- valid_in held high while done is high starts a new operation in that same cycle.
- q, r and sign_o hold until the next done; they never change at any other time.

## Configuration
- TOP_R2_LZC_SKIP_EN defined: iteration count from the leading-zero difference, with the early out as above.
- TOP_R2_LZC_SKIP_EN undefined:
  - NORM skips the lzc step and always runs WIDTH CALC iterations, so latency is fixed at WIDTH+2.
  - Divide by zero still bypasses CALC.
- Results must be bit-identical in both builds.

## Structure
- Package top_r2_pkg holds:
  - the state enum {IDLE, NORM, CALC, FIX};
  - default WIDTH/EXPWIDTH constants;
  - a helper returning the signed-overflow constant.
- One sub-module, top_r2_lzc: combinational leading-zero counter with a WIDTH input and an EXPWIDTH output; returns WIDTH for a zero input.
- Two instances of top_r2_lzc, one per operand.

## Test plan
- Unsigned 100 / 7, sign=0 -> q=14, r=2, sign_o=0, done after 2+iters cycles (lzc diff 4, iters 5, done at edge 7).
- Signed −100 / 7 -> q=0xFFFFFFF2 (−14), r=0xFFFFFFFE (−2); and 100 / −7 -> q=−14, r=2.
- Divisor 0 with zdividend 0x12345678, both modes -> q=0xFFFFFFFF, r=0x12345678, done at edge 2.
- Signed 0x80000000 / 0xFFFFFFFF -> q=0x80000000, r=0.
- Unsigned 0xFFFFFFFF / 1 -> q=0xFFFFFFFF, r=0, 34-cycle latency; back-to-back requests, with valid_in held high in the done cycle, start the next op immediately and are otherwise ignored while free=0.
- Assert rst_n during CALC -> next cycle free=1, done=0, q=r=0; no spurious done follows.
